// File: rtl/conv_stream_sequencer_if.sv
// Weight-source, pixel-source and accelerator-side signals of conv_stream_sequencer.
// The master modport is the sequencer; the slave modport is the sources plus accelerator.
interface conv_stream_sequencer_if #(
   parameter int DATA_WIDTH = 16,
   parameter int AW         = 6
);
   logic                  w_valid;
   logic                  w_ready;
   logic [DATA_WIDTH-1:0] w_data;
   logic                  p_valid;
   logic                  p_ready;
   logic [DATA_WIDTH-1:0] p_data;
   logic                  acc_start;
   logic                  acc_load_weights;
   logic [AW-1:0]         acc_weight_addr;
   logic [DATA_WIDTH-1:0] acc_weight_in;
   logic                  acc_pixel_valid;
   logic [DATA_WIDTH-1:0] acc_pixel_data;
   logic                  acc_output_valid;

   modport master (
      input  w_valid, w_data, p_valid, p_data, acc_output_valid,
      output w_ready, p_ready, acc_start, acc_load_weights, acc_weight_addr,
             acc_weight_in, acc_pixel_valid, acc_pixel_data
   );

   modport slave (
      output w_valid, w_data, p_valid, p_data, acc_output_valid,
      input  w_ready, p_ready, acc_start, acc_load_weights, acc_weight_addr,
             acc_weight_in, acc_pixel_valid, acc_pixel_data
   );
endinterface

// File: rtl/conv_stream_sequencer.sv
// Sequences one frame (weights, pixels, zero flush, output drain) through the conv accelerator.
// Optional drain watchdog is enabled by defining CONV_SEQ_TIMEOUT_EN.
module conv_stream_sequencer #(
   parameter int DATA_WIDTH     = 16,
   parameter int IMAGE_WIDTH    = 10,
   parameter int POF            = 4,
   parameter int NKX            = 3,
   parameter int NKY            = 3,
   parameter int FLUSH_CYCLES   = 30,
   parameter int TIMEOUT_CYCLES = 4096,
   localparam int TOTAL_WEIGHTS = POF * NKX * NKY,
   localparam int NPIX          = IMAGE_WIDTH * IMAGE_WIDTH,
   localparam int EXPECTED_OUT  = NPIX - ((NKY - 1) * IMAGE_WIDTH + NKX - 1),
   localparam int AW            = $clog2(TOTAL_WEIGHTS),
   localparam int CW            = $clog2(NPIX + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic          error,
   output logic [CW-1:0] out_count,
   conv_stream_sequencer_if.master bus
);
   localparam int PW = $clog2(NPIX + 1);
   localparam int FW = $clog2(FLUSH_CYCLES + 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD_W = 3'd1,
      ST_STREAM = 3'd2,
      ST_FLUSH  = 3'd3,
      ST_DRAIN  = 3'd4,
      ST_DONE   = 3'd5
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [AW-1:0]   r_widx;
   logic [PW-1:0]   r_pidx;
   logic [FW-1:0]   r_fidx;
   logic [CW-1:0]   r_out_count;
   logic            r_acc_start;
   logic            r_load;
   logic [AW-1:0]   r_waddr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic            r_pvalid;
   logic [DATA_WIDTH-1:0] r_pdata;
   logic            w_wt_xfer;
   logic            w_px_xfer;
   logic            w_start_acc;
   logic            w_count_full;
   logic            w_timeout;

   // Source readiness depends on state only, never on the valids.
   assign bus.w_ready  = (r_state == ST_LOAD_W);
   assign bus.p_ready  = (r_state == ST_STREAM);
   assign w_wt_xfer    = bus.w_valid && (r_state == ST_LOAD_W);
   assign w_px_xfer    = bus.p_valid && (r_state == ST_STREAM);
   assign w_start_acc  = start && (r_state == ST_IDLE);
   assign w_count_full = (r_out_count == CW'(EXPECTED_OUT));

`ifdef CONV_SEQ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] r_to_cnt;
   logic          r_error;

   // Drain watchdog: restarts on every accelerator result strobe.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_to_cnt <= {TW{1'b0}};
      end else if (r_state != ST_DRAIN || bus.acc_output_valid) begin
         r_to_cnt <= {TW{1'b0}};
      end else begin
         r_to_cnt <= r_to_cnt + TW'(1);
      end
   end

   assign w_timeout = (r_state == ST_DRAIN) && !bus.acc_output_valid && !w_count_full &&
                      (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

   // Sticky error flag, cleared only by the next accepted start.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_error <= 1'b0;
      end else if (w_start_acc) begin
         r_error <= 1'b0;
      end else if (w_timeout) begin
         r_error <= 1'b1;
      end else begin
         r_error <= r_error;
      end
   end

   assign error = r_error;
`else
   assign w_timeout = 1'b0;
   assign error     = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_next;
   end

   // Next state: the last transfer of a phase and the phase change share one edge.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:   if (start) w_next = ST_LOAD_W; else w_next = ST_IDLE;
         ST_LOAD_W: if (w_wt_xfer && r_widx == AW'(TOTAL_WEIGHTS - 1)) w_next = ST_STREAM;
                    else w_next = ST_LOAD_W;
         ST_STREAM: if (w_px_xfer && r_pidx == PW'(NPIX - 1)) w_next = ST_FLUSH;
                    else w_next = ST_STREAM;
         ST_FLUSH:  if (r_fidx == FW'(FLUSH_CYCLES - 1)) w_next = ST_DRAIN;
                    else w_next = ST_FLUSH;
         ST_DRAIN:  if (w_count_full || w_timeout) w_next = ST_DONE;
                    else w_next = ST_DRAIN;
         ST_DONE:   w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   // Phase counters and the saturating result counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_widx      <= {AW{1'b0}};
         r_pidx      <= {PW{1'b0}};
         r_fidx      <= {FW{1'b0}};
         r_out_count <= {CW{1'b0}};
      end else begin
         if (r_state == ST_IDLE) begin
            r_widx <= {AW{1'b0}};
            r_pidx <= {PW{1'b0}};
         end else begin
            if (w_wt_xfer) r_widx <= r_widx + AW'(1);
            if (w_px_xfer) r_pidx <= r_pidx + PW'(1);
         end
         if (r_state == ST_FLUSH) r_fidx <= r_fidx + FW'(1);
         else                     r_fidx <= {FW{1'b0}};
         // out_count survives IDLE so a timed-out frame's partial count stays visible.
         if (w_start_acc)
            r_out_count <= {CW{1'b0}};
         else if (r_state != ST_IDLE && bus.acc_output_valid && !w_count_full)
            r_out_count <= r_out_count + CW'(1);
         else
            r_out_count <= r_out_count;
      end
   end

   // Registered accelerator pins, one cycle behind the source transfer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_acc_start <= 1'b0;
         r_load      <= 1'b0;
         r_waddr     <= {AW{1'b0}};
         r_wdata     <= {DATA_WIDTH{1'b0}};
         r_pvalid    <= 1'b0;
         r_pdata     <= {DATA_WIDTH{1'b0}};
      end else begin
         r_acc_start <= (w_next == ST_LOAD_W) || (w_next == ST_STREAM) ||
                        (w_next == ST_FLUSH) || (w_next == ST_DRAIN);
         r_load      <= w_wt_xfer;
         if (w_wt_xfer) begin
            r_waddr <= r_widx;
            r_wdata <= bus.w_data;
         end
         r_pvalid    <= w_px_xfer || (r_state == ST_FLUSH);
         r_pdata     <= w_px_xfer ? bus.p_data : {DATA_WIDTH{1'b0}};
      end
   end

   assign busy                 = (r_state != ST_IDLE);
   assign done                 = (r_state == ST_DONE);
   assign out_count            = r_out_count;
   assign bus.acc_start        = r_acc_start;
   assign bus.acc_load_weights = r_load;
   assign bus.acc_weight_addr  = r_waddr;
   assign bus.acc_weight_in    = r_wdata;
   assign bus.acc_pixel_valid  = r_pvalid;
   assign bus.acc_pixel_data   = r_pdata;
endmodule
